lab2_pio_gen: RTL and testbench

LAB2_PIO_GEN -- requirements
Module: lab2_pio_gen

---
 rtl/lab2_pio_gen.sv | 131 +++++++++++++
 tb/tb_lab2_pio_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_pio_gen.sv
// lab2_pio_gen: Avalon-MM parallel I/O port with set/clear, direction,
// edge capture and level interrupt.
// Ports: clk, reset (sync, active-high); address, chipselect, write_n,
//   writedata, readdata (Avalon-MM slave, zero wait states);
//   in_port (async inputs), out_port, port_oe, irq.
module lab2_pio_gen #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] port_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_val;
    logic             wr;
    logic             wd_unused;

    assign wd = writedata[WIDTH-1:0];
    // Upper write bits beyond WIDTH are intentionally ignored.
    assign wd_unused = ^writedata;
    assign wr = chipselect & ~write_n;

    // Edge type is fixed at elaboration time.
    always_comb begin
        edge_det = '0;
        if (EDGE_MODE == 0) begin
            edge_det = in_sync & ~in_prev;
        end else if (EDGE_MODE == 1) begin
            edge_det = ~in_sync & in_prev;
        end else begin
            edge_det = in_sync ^ in_prev;
        end
    end

    assign cap_clr = (wr && address == ADDR_EDGECAP) ? wd : '0;

    // Input synchronizer and edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            in_sync   <= '0;
            in_prev   <= '0;
        end else begin
            sync_meta <= in_port;
            in_sync   <= sync_meta;
            in_prev   <= in_sync;
        end
    end

    // Output data with direct load, set and clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data_out <= wd;
                ADDR_OUTSET:   data_out <= data_out | wd;
                ADDR_OUTCLEAR: data_out <= data_out & ~wd;
                default:       data_out <= data_out;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir      <= '0;
            irq_mask <= '0;
        end else if (wr) begin
            if (address == ADDR_DIR) begin
                dir <= wd;
            end
            if (address == ADDR_IRQMASK) begin
                irq_mask <= wd;
            end
        end
    end

    // New edges are OR-ed in after the clear so a coincident edge wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_det;
        end
    end

    // Reads are purely combinational and independent of chipselect.
    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = in_sync;
            ADDR_DIR:     rd_val = dir;
            ADDR_IRQMASK: rd_val = irq_mask;
            ADDR_EDGECAP: rd_val = edge_cap;
            default:      rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);
    assign out_port = data_out;
    assign port_oe  = dir;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_lab2_pio_gen.sv
// Directed self-checking bench for lab2_pio_gen
// (WIDTH=8, RESET_VALUE=8'hA5, EDGE_MODE=0).
module tb_lab2_pio_gen;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  port_oe;
    logic        irq;

    int total = 0;
    int bad   = 0;

    lab2_pio_gen #(
        .WIDTH(8),
        .RESET_VALUE(8'hA5),
        .EDGE_MODE(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .out_port(out_port),
        .port_oe(port_oe),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset      = 1'b1;
        in_port    = 8'h00;
        address    = 3'd0;
        writedata  = 32'hFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        tick();
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        total++;
        if (out_port !== 8'hA5) begin
            bad++;
            $display("FAIL rst_out got %h want a5", out_port);
        end
        total++;
        if (port_oe !== 8'h00) begin
            bad++;
            $display("FAIL rst_oe got %h want 00", port_oe);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL rst_irq got %b want 0", irq);
        end
        for (int a = 0; a < 4; a++) begin
            rd(3'(a), v);
            total++;
            if (v !== 32'h0) begin
                bad++;
                $display("FAIL rst_rd%0d got %h want 0", a, v);
            end
        end
        tick();
        tick();
        rd(3'd3, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL rst_nospur got %h want 0", v);
        end
    endtask

    task automatic test_data_ops();
        logic [31:0] v;
        wr(3'd0, 32'hFFFF_FF0F);
        total++;
        if (out_port !== 8'h0F) begin
            bad++;
            $display("FAIL data_wr got %h want 0f", out_port);
        end
        wr(3'd4, 32'hC0);
        total++;
        if (out_port !== 8'hCF) begin
            bad++;
            $display("FAIL outset got %h want cf", out_port);
        end
        wr(3'd5, 32'h03);
        total++;
        if (out_port !== 8'hCC) begin
            bad++;
            $display("FAIL outclr got %h want cc", out_port);
        end
        rd(3'd4, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL rd_outset got %h want 0", v);
        end
        rd(3'd5, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL rd_outclr got %h want 0", v);
        end
        wr(3'd1, 32'h5A);
        total++;
        if (port_oe !== 8'h5A) begin
            bad++;
            $display("FAIL dir_oe got %h want 5a", port_oe);
        end
        rd(3'd1, v);
        total++;
        if (v !== 32'h5A) begin
            bad++;
            $display("FAIL dir_rd got %h want 5a", v);
        end
        rd(3'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL data_rd_in got %h want 0", v);
        end
    endtask

    task automatic test_sync_edge();
        logic [31:0] v;
        in_port = 8'h81;
        tick();
        rd(3'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL sync_lag1 got %h want 0", v);
        end
        tick();
        rd(3'd0, v);
        total++;
        if (v !== 32'h81) begin
            bad++;
            $display("FAIL sync_lag2 got %h want 81", v);
        end
        rd(3'd3, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL cap_early got %h want 0", v);
        end
        tick();
        rd(3'd3, v);
        total++;
        if (v !== 32'h81) begin
            bad++;
            $display("FAIL cap_set got %h want 81", v);
        end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_nomask got %b want 0", irq);
        end
        wr(3'd2, 32'h01);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_on got %b want 1", irq);
        end
        rd(3'd2, v);
        total++;
        if (v !== 32'h01) begin
            bad++;
            $display("FAIL mask_rd got %h want 01", v);
        end
        wr(3'd3, 32'h01);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_off got %b want 0", irq);
        end
        rd(3'd3, v);
        total++;
        if (v !== 32'h80) begin
            bad++;
            $display("FAIL cap_w1c got %h want 80", v);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        in_port = 8'h80;
        tick();
        tick();
        tick();
        in_port = 8'h81;
        tick();
        tick();
        wr(3'd3, 32'h01);
        rd(3'd3, v);
        total++;
        if (v !== 32'h81) begin
            bad++;
            $display("FAIL set_wins got %h want 81", v);
        end
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL set_wins_irq got %b want 1", irq);
        end
        wr(3'd3, 32'h01);
        rd(3'd3, v);
        total++;
        if (v !== 32'h80) begin
            bad++;
            $display("FAIL clr_after got %h want 80", v);
        end
    endtask

    task automatic test_unused_addr();
        logic [31:0] v;
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        address    = 3'd0;
        writedata  = 32'h00;
        chipselect = 1'b0;
        write_n    = 1'b0;
        tick();
        write_n    = 1'b1;
        rd(3'd6, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL rd6 got %h want 0", v);
        end
        rd(3'd7, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL rd7 got %h want 0", v);
        end
        total++;
        if (out_port !== 8'hCC) begin
            bad++;
            $display("FAIL unused_out got %h want cc", out_port);
        end
        total++;
        if (port_oe !== 8'h5A) begin
            bad++;
            $display("FAIL unused_oe got %h want 5a", port_oe);
        end
        rd(3'd2, v);
        total++;
        if (v !== 32'h01) begin
            bad++;
            $display("FAIL unused_mask got %h want 01", v);
        end
        rd(3'd3, v);
        total++;
        if (v !== 32'h80) begin
            bad++;
            $display("FAIL unused_cap got %h want 80", v);
        end
    endtask

    task automatic test_back_to_back();
        address    = 3'd0;
        writedata  = 32'h11;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        address    = 3'd4;
        writedata  = 32'h22;
        tick();
        address    = 3'd5;
        writedata  = 32'h01;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        total++;
        if (out_port !== 8'h32) begin
            bad++;
            $display("FAIL b2b_out got %h want 32", out_port);
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        test_reset();
        test_data_ops();
        test_sync_edge();
        test_irq();
        test_set_wins();
        test_unused_addr();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
